// File: rtl/uart_rx_led.sv
// 8N1 UART receiver that shows the low nibble of the last good byte on led3..0 and flags framing errors on led4.
// Latency: a byte decision comes SYNC_LEN cycles plus the stop-bit sample point after the pin; LEDs update the cycle after.
// No backpressure: the serial line cannot be stalled. Optional echo transmitter under `UART_RX_ECHO_EN` (a busy echo drops the new byte).
module uart_rx_led #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SYNC_LEN = 2
) (
    input  logic clk,
    input  logic nRst,
    input  logic rx,
    input  logic sw2,
    input  logic sw1,
    input  logic sw0,
    output logic tx,
    output logic led4,
    output logic led3,
    output logic led2,
    output logic led1,
    output logic led0
);

    // Rounded bit period in clock cycles, evaluated only at elaboration time.
    function automatic int div_round(input int baud);
        return (CLK_HZ + baud / 2) / baud;
    endfunction

    localparam logic [12:0] BIT0 = 13'(div_round(9600));
    localparam logic [12:0] BIT1 = 13'(div_round(19200));
    localparam logic [12:0] BIT2 = 13'(div_round(38400));
    localparam logic [12:0] BIT3 = 13'(div_round(57600));
    localparam logic [12:0] BIT4 = 13'(div_round(115200));
    localparam logic [12:0] BIT5 = 13'(div_round(230400));
    localparam logic [12:0] BIT6 = 13'(div_round(460800));
    localparam logic [12:0] BIT7 = 13'(div_round(921600));

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [SYNC_LEN-1:0] sync;
    logic [SYNC_LEN-1:0] flush;
    logic                rx_s;
    logic                rx_prev;
    logic                armed;
    logic [12:0]         sel_bit;

    state_t      state;
    logic [12:0] cnt;
    logic [12:0] bit_len;
    logic [12:0] half_len;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [3:0]  led_q;
    logic        err_q;

    assign rx_s = sync[SYNC_LEN-1];
    assign {led3, led2, led1, led0} = led_q;
    assign led4 = err_q;

    // Bit period for the current switch setting; only sampled at start-bit detection.
    always_comb begin
        sel_bit = BIT0;
        case ({sw2, sw1, sw0})
            3'd0: sel_bit = BIT0;
            3'd1: sel_bit = BIT1;
            3'd2: sel_bit = BIT2;
            3'd3: sel_bit = BIT3;
            3'd4: sel_bit = BIT4;
            3'd5: sel_bit = BIT5;
            3'd6: sel_bit = BIT6;
            default: sel_bit = BIT7;
        endcase
    end

    // Synchroniser, edge history and arming. The preset 1s must flush out before a high
    // level counts towards arming, so a line held low from reset never arms the receiver.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync    <= '1;
            flush   <= '0;
            rx_prev <= 1'b1;
            armed   <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_LEN-2:0], rx};
            flush   <= {flush[SYNC_LEN-2:0], 1'b1};
            rx_prev <= rx_s;
            if (flush[SYNC_LEN-1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

`ifdef UART_RX_ECHO_EN
    logic        echo_go;
    logic [7:0]  echo_dat;
    logic [12:0] echo_len;
`endif

    // Receive FSM: start detect, mid-bit resample, 8 data samples, stop check, break wait.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_len  <= BIT0;
            half_len <= BIT0 >> 1;
            bit_idx  <= '0;
            shreg    <= '0;
            led_q    <= '0;
            err_q    <= 1'b0;
`ifdef UART_RX_ECHO_EN
            echo_go  <= 1'b0;
            echo_dat <= '0;
            echo_len <= BIT0;
`endif
        end else begin
`ifdef UART_RX_ECHO_EN
            echo_go <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (armed && rx_prev && !rx_s) begin
                        state    <= S_START;
                        cnt      <= '0;
                        bit_len  <= sel_bit;
                        half_len <= sel_bit >> 1;
                    end
                end
                S_START: begin
                    if (cnt == half_len - 13'd1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                S_DATA: begin
                    if (cnt == bit_len - 13'd1) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                S_STOP: begin
                    if (cnt == bit_len - 13'd1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            led_q <= shreg[3:0];
                            err_q <= 1'b0;
                            state <= S_IDLE;
`ifdef UART_RX_ECHO_EN
                            echo_go  <= 1'b1;
                            echo_dat <= shreg;
                            echo_len <= bit_len;
`endif
                        end else begin
                            err_q <= 1'b1;
                            state <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_ECHO_EN
    logic        tx_busy;
    logic [8:0]  tx_sh;
    logic [12:0] tx_cnt;
    logic [12:0] tx_len;
    logic [3:0]  tx_left;

    // Echo transmitter: start bit goes out the cycle after the LEDs change; a byte
    // finishing while an echo is still in flight is simply not echoed.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_cnt  <= '0;
            tx_len  <= BIT0;
            tx_left <= '0;
        end else if (!tx_busy) begin
            if (echo_go) begin
                tx      <= 1'b0;
                tx_sh   <= {1'b1, echo_dat};
                tx_len  <= echo_len;
                tx_cnt  <= '0;
                tx_left <= 4'd9;
                tx_busy <= 1'b1;
            end
        end else if (tx_cnt == tx_len - 13'd1) begin
            tx_cnt <= '0;
            if (tx_left == 4'd0) begin
                tx_busy <= 1'b0;
            end else begin
                tx      <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[8:1]};
                tx_left <= tx_left - 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + 13'd1;
        end
    end
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_led.sv
// Directed bench for uart_rx_led: reset/arming, good bytes, glitch, framing error, baud switching, mid-frame reset.
module tb_uart_rx_led;

    logic       clk;
    logic       nRst;
    logic       rx;
    logic [2:0] sw;
    logic       tx;
    logic       led4, led3, led2, led1, led0;
    logic [4:0] leds;

    int checks = 0;
    int errors = 0;

`ifdef UART_RX_ECHO_EN
    localparam int POST = 5000;
`else
    localparam int POST = 600;
`endif

    assign leds = {led4, led3, led2, led1, led0};

    uart_rx_led dut (
        .clk (clk),
        .nRst(nRst),
        .rx  (rx),
        .sw2 (sw[2]),
        .sw1 (sw[1]),
        .sw0 (sw[0]),
        .tx  (tx),
        .led4(led4),
        .led3(led3),
        .led2(led2),
        .led1(led1),
        .led0(led0)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full 8N1 frame with a chosen stop-bit level; line returns high afterwards.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int bitc);
        rx = 1'b0;
        wait_cycles(bitc);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cycles(bitc);
        end
        rx = stop;
        wait_cycles(bitc);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rx   = 1'b0;
        sw   = 3'b100;
        nRst = 1'b0;
        wait_cycles(5);
        checks++;
        if (leds !== 5'b00000) begin
            errors++;
            $display("FAIL reset_leds_during got=%b want=%b", leds, 5'b00000);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx_during got=%b want=1", tx);
        end
        nRst = 1'b1;
        wait_cycles(20000);
        checks++;
        if (leds !== 5'b00000) begin
            errors++;
            $display("FAIL held_low_leds got=%b want=%b", leds, 5'b00000);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL held_low_tx got=%b want=1", tx);
        end
        rx = 1'b1;
        wait_cycles(100);
    endtask

    task automatic test_good_byte;
        logic [9:0] exp_frame;
        exp_frame = 10'b1101001010;  // bit0 first: 0,1,0,1,0,0,1,0,1,1
        sw = 3'b100;
        fork
            send_byte(8'hA5, 1'b1, 434);
`ifdef UART_RX_ECHO_EN
            begin
                int t;
                t = 0;
                while (tx !== 1'b0 && t < 20000) begin
                    @(negedge clk);
                    t++;
                end
                checks++;
                if (t >= 20000) begin
                    errors++;
                    $display("FAIL echo_start timeout got=%0d cycles want<20000", t);
                end else begin
                    wait_cycles(217);
                    for (int b = 0; b < 10; b++) begin
                        checks++;
                        if (tx !== exp_frame[b]) begin
                            errors++;
                            $display("FAIL echo_bit%0d got=%b want=%b", b, tx, exp_frame[b]);
                        end
                        wait_cycles(434);
                    end
                end
            end
`endif
        join
        wait_cycles(POST);
        checks++;
        if (leds !== 5'b00101) begin
            errors++;
            $display("FAIL good_a5 got=%b want=%b", leds, 5'b00101);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL good_a5_tx_idle got=%b want=1", tx);
        end
    endtask

    task automatic test_glitch;
        sw = 3'b000;
        rx = 1'b0;
        wait_cycles(100);
        rx = 1'b1;
        wait_cycles(3000);
        checks++;
        if (leds !== 5'b00101) begin
            errors++;
            $display("FAIL glitch_leds got=%b want=%b", leds, 5'b00101);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL glitch_tx got=%b want=1", tx);
        end
    endtask

    task automatic test_framing;
        sw = 3'b100;
        send_byte(8'h3C, 1'b0, 434);
        wait_cycles(600);
        checks++;
        if (leds !== 5'b10101) begin
            errors++;
            $display("FAIL framing_err got=%b want=%b", leds, 5'b10101);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL framing_tx got=%b want=1", tx);
        end
        send_byte(8'h0F, 1'b1, 434);
        wait_cycles(POST);
        checks++;
        if (leds !== 5'b01111) begin
            errors++;
            $display("FAIL recover_0f got=%b want=%b", leds, 5'b01111);
        end
    endtask

    task automatic test_baud_switch;
        sw = 3'b100;
        fork
            send_byte(8'h96, 1'b1, 434);
            begin
                wait_cycles(434 * 4);
                sw = 3'b111;
            end
        join
        wait_cycles(POST);
        checks++;
        if (leds !== 5'b00110) begin
            errors++;
            $display("FAIL switch_96 got=%b want=%b", leds, 5'b00110);
        end
        send_byte(8'hC3, 1'b1, 54);
        wait_cycles(800);
        checks++;
        if (leds !== 5'b00011) begin
            errors++;
            $display("FAIL fast_c3 got=%b want=%b", leds, 5'b00011);
        end
    endtask

    task automatic test_reset_mid;
        sw = 3'b100;
        rx = 1'b0;
        wait_cycles(434);
        rx = 1'b1;
        wait_cycles(434);
        rx = 1'b0;
        wait_cycles(434 * 2);
        nRst = 1'b0;
        rx   = 1'b1;
        wait_cycles(5);
        checks++;
        if (leds !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_leds got=%b want=%b", leds, 5'b00000);
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL midreset_tx got=%b want=1", tx);
        end
        nRst = 1'b1;
        wait_cycles(100);
        send_byte(8'h81, 1'b1, 434);
        wait_cycles(POST);
        checks++;
        if (leds !== 5'b00001) begin
            errors++;
            $display("FAIL after_reset_81 got=%b want=%b", leds, 5'b00001);
        end
    endtask

    initial begin
        nRst = 1'b0;
        rx   = 1'b1;
        sw   = 3'b100;
        test_reset();
        test_good_byte();
        test_glitch();
        test_framing();
        test_baud_switch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
